// File: rtl/aes_128_key_sched.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, with a registered read port for the downstream cipher core.
module aes_128_key_sched #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic {IDLE, EXPAND} state_t;

  // FIPS-197 forward S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state, state_nxt;
  logic [3:0]     rnd;
  logic [127:0]   rk_mem [11];
  logic           load_acc, round_last;
  logic [127:0]   prev_rk, next_rk, rd_data;
  logic [31:0]    w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    load_acc   = 1'b0;
    round_last = 1'b0;
    case (state)
      IDLE: begin
        if (key_load) begin
          load_acc  = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (rnd == 4'd10) begin
          round_last = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One key-schedule round from rk[rnd-1]; w0 is the most significant word.
  assign prev_rk = (rnd != 4'd0 && rnd <= 4'd10) ? rk_mem[rnd - 4'd1] : '0;
  assign {w0, w1, w2, w3} = prev_rk;
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]) ^ rcon(rnd), sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  assign rd_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;
  assign busy    = (state == EXPAND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rnd        <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rk_out     <= '0;
    end else begin
      state  <= state_nxt;
      done   <= round_last;
      rk_out <= rd_data;
      if (load_acc) begin
        rnd        <= 4'd1;
        keys_valid <= 1'b0;
      end else if (round_last) begin
        rnd        <= '0;
        keys_valid <= 1'b1;
      end else if (state == EXPAND) begin
        rnd <= rnd + 4'd1;
      end
    end
  end

  // NOTE: the key store is cleared only when CLEAR_ON_RESET is set; otherwise
  // reset merely blocks writes so old round keys survive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < 11; i++) rk_mem[i] <= '0;
      end
    end else if (load_acc) begin
      rk_mem[0] <= key_in;
    end else if (state == EXPAND) begin
      for (int i = 1; i < 11; i++) begin
        if (rnd == 4'(i)) rk_mem[i] <= next_rk;
      end
    end
  end

endmodule

// File: tb/tb_aes_128_key_sched.sv
// Self-checking bench for aes_128_key_sched: a GF(2^8) reference model and a
// read scoreboard, with a second instance built without storage clear.
module tb_aes_128_key_sched;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst, key_load;
  logic [127:0] key_in;
  logic [3:0]   rk_idx;
  logic         busy, done, keys_valid;
  logic [127:0] rk_out;
  logic         busy_nc, done_nc, keys_valid_nc;
  logic [127:0] rk_out_nc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        tag;
    bit           nc;
    logic [127:0] exp;
  } rd_t;
  rd_t sb[$];

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  aes_128_key_sched #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_128_key_sched #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy_nc), .done(done_nc), .keys_valid(keys_valid_nc),
    .rk_idx(rk_idx), .rk_out(rk_out_nc)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box built from the multiplicative inverse plus the affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, rot, t;
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      {w0, w1, w2, w3} = exp_rk[r-1];
      rot = {w3[23:0], w3[31:24]};
      t = {sbox_m[rot[31:24]] ^ rc, sbox_m[rot[23:16]], sbox_m[rot[15:8]], sbox_m[rot[7:0]]};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
      rc = xtime(rc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read index, push the expected data, pop it when rk_out updates.
  task automatic rd(input logic [3:0] idx, input bit nc, input logic [127:0] exp, input string tag);
    rd_t e;
    rk_idx = idx;
    sb.push_back('{tag: tag, nc: nc, exp: exp});
    tick();
    e = sb.pop_front();
    check(e.tag, e.nc ? rk_out_nc : rk_out, e.exp);
  endtask

  task automatic load(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Observe a fixed window starting just after the load edge; optionally
  // pulse a second load at sample inj.
  task automatic run_exp(input int inj, input logic [127:0] inj_key,
                         output int nb, output int nd, output int done_at);
    nb = 0; nd = 0; done_at = -1;
    for (int i = 0; i < 14; i++) begin
      if (busy) nb++;
      if (done) begin nd++; done_at = i; end
      key_load = (i == inj);
      if (i == inj) key_in = inj_key;
      tick();
    end
    key_load = 1'b0;
  endtask

  initial begin
    int nb, nd, da, t1, t2;
    logic kv_done, kv_next;
    logic [127:0] key_a, key_b, key_r;

    rst = 1'b1; key_load = 1'b0; key_in = '0; rk_idx = '0;
    build_sbox();
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kv", keys_valid, 0);
    check("rst_rk_out", rk_out, 0);

    // Scenario 1: FIPS key
    load(FIPS_KEY);
    run_exp(-1, '0, nb, nd, da);
    check("s1_busy_cycles", nb, 10);
    check("s1_done_pulses", nd, 1);
    check("s1_done_at", da, 10);
    check("s1_kv", keys_valid, 1);
    model_expand(FIPS_KEY);
    rd(1, 0, FIPS_RK1, "s1_rk1");
    rk_idx = 10;
    check("s1_lag", rk_out, FIPS_RK1);
    rd(10, 0, FIPS_RK10, "s1_rk10");
    rd(0, 0, FIPS_KEY, "s1_rk0");
    rd(5, 0, exp_rk[5], "s1_rk5_model");

    // Scenario 2: all-zero key
    load('0);
    run_exp(-1, '0, nb, nd, da);
    check("s2_done_pulses", nd, 1);
    rd(1, 0, ZERO_RK1, "s2_rk1");
    rd(10, 0, ZERO_RK10, "s2_rk10");
    rd(12, 0, '0, "s2_idx12");
    rd(15, 0, '0, "s2_idx15");

    // Scenario 3: load while busy is ignored
    load(FIPS_KEY);
    run_exp(3, '0, nb, nd, da);
    check("s3_busy_cycles", nb, 10);
    check("s3_done_pulses", nd, 1);
    check("s3_done_at", da, 10);
    rd(1, 0, FIPS_RK1, "s3_rk1");
    rd(10, 0, FIPS_RK10, "s3_rk10");

    // Scenario 4: reset in the middle of an expansion
    load(FIPS_KEY);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s4_busy", busy, 0);
    check("s4_done", done, 0);
    check("s4_kv", keys_valid, 0);
    check("s4_rk_out", rk_out, 0);
    for (int i = 0; i < 11; i++) rd(4'(i), 0, '0, $sformatf("s4_clr_rk%0d", i));
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    check("s4_no_done", nd, 0);
    key_r = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_r);
    load(key_r);
    run_exp(-1, '0, nb, nd, da);
    check("s4_fresh_done", nd, 1);
    rd(3, 0, exp_rk[3], "s4_fresh_rk3");
    rd(10, 0, exp_rk[10], "s4_fresh_rk10");

    // Scenario 5: key_load held high across two expansions
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    key_in = key_a; key_load = 1'b1;
    tick();
    nd = 0; t1 = -1; t2 = -1; kv_done = 1'bx; kv_next = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (nd == 1 && i == t1 + 1) kv_next = keys_valid;
      if (done) begin
        nd++;
        if (nd == 1) begin
          t1 = i; kv_done = keys_valid; key_in = key_b;
        end else begin
          t2 = i; key_load = 1'b0;
          break;
        end
      end
      tick();
    end
    key_load = 1'b0;
    check("s5_two_dones", nd, 2);
    check("s5_kv_at_done", kv_done, 1);
    check("s5_kv_after_done", kv_next, 0);
    check("s5_done_gap", t2 - t1, 11);
    model_expand(key_b);
    rd(0, 0, key_b, "s5_rk0");
    rd(10, 0, exp_rk[10], "s5_rk10");

    // Scenario 6: storage survives reset when clearing is disabled
    load(FIPS_KEY);
    run_exp(-1, '0, nb, nd, da);
    check("s6_nc_done", nd, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_nc_kv", keys_valid_nc, 0);
    rd(10, 1, FIPS_RK10, "s6_nc_rk10");
    rd(1, 1, FIPS_RK1, "s6_nc_rk1");
    rd(10, 0, '0, "s6_clr_rk10");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_128_key_sched.md
Name: aes_128_key_sched

Overview:
Iterative AES-128 key-expansion unit. It sits directly upstream of the multicycle aes_128 encryption core. It expands one 128-bit cipher key into the 11 round keys (rk0..rk10), producing one round key per clock. The keys are held in an internal register file, and a registered read port lets the core fetch any round key by index. This makes the core independent of the key timing on the bus.

Parameters:
CLEAR_ON_RESET, 1, when 1 the rk0..rk10 storage is cleared to 0 on reset; when 0 the storage is left untouched by reset (control state is still reset).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
key_in  in  128  cipher key; sampled only on an accepted key_load
key_load  in  1  start-expansion request; one-cycle pulse or level
busy  out  1  high while expansion is in progress
done  out  1  one-cycle pulse when rk10 has been written
keys_valid  out  1  high when rk0..rk10 all belong to the most recently loaded key
rk_idx  in  4  round-key read index, 0..10
rk_out  out  128  registered read data: rk[rk_idx] of the previous cycle

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, keys_valid=0, rk_out=0, round counter=0.
  - rk0..rk10 are cleared to 0 if CLEAR_ON_RESET=1.
  - rst overrides every other input in the same cycle.
- FSM states: IDLE and EXPAND.
- IDLE behaviour:
  - key_load=1 at edge E0: rk0<=key_in, rnd<=1, busy<=1, keys_valid<=0, state<=EXPAND.
- EXPAND behaviour (one round per edge, rnd=1..10):
  - Key schedule from rk[rnd-1] = {w0,w1,w2,w3}, w0 in bits [127:96].
  - t = SubWord(RotWord(w3)) ^ {Rcon[rnd],24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the FIPS-197 forward S-box to each byte. The four S-box instances are combinational and live inside this block.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2; rk[rnd]<={n0,n1,n2,n3}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex).
  - rnd increments by 1 per edge.
  - On the edge writing rk10 (E10): state<=IDLE, busy<=0, done<=1, keys_valid<=1, rnd<=0.
- Latency and handshake:
  - Load at E0 gives busy high from E0 through E10 and done high for exactly the cycle after E10 (E10..E11).
  - done always deasserts the cycle after it rises.
  - Back-to-back: a key_load in the done cycle is accepted; keys_valid returns to 0 at that edge.
- key_load while busy is ignored. No restart occurs, the key is not captured, and the in-flight expansion completes unchanged.
  - A level-held key_load therefore re-triggers on the first IDLE cycle after done.
- Read port:
  - rk_out <= rk[rk_idx] every edge, independent of state.
  - rk_idx 11..15 gives rk_out<=0.
  - Reads during EXPAND return current storage contents. Entries not yet rewritten hold the previous key's values. keys_valid=0 marks these as untrusted.
  - An index read on the same edge that writes that entry returns the old value. The new value appears one edge later.
- Reset mid-EXPAND: the expansion is aborted, all reset values above apply, and no done pulse is issued.
- No other arithmetic: all operations are XOR/byte-substitution on fixed 32-bit words, with no carries.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, load pulse at E0:
   - busy high for 10 cycles, done single pulse after E10.
   - Reads return rk1=a0fafe1788542cb123a339392a6c7605 and rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_out lags rk_idx by one cycle.
2. All-zero key:
   - rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
   - rk_idx=12 reads 0.
3. Ignored load:
   - Load FIPS key, then pulse key_load with the all-zero key at E4.
   - Results equal scenario 1; exactly one done pulse; busy never drops early.
4. Reset mid-operation:
   - Assert rst at E5 of an expansion.
   - Next cycle: busy=0, done=0, keys_valid=0, rk_out=0. With CLEAR_ON_RESET=1, all indices read 0.
   - A fresh load afterwards completes normally.
5. Back-to-back:
   - Hold key_load high through two expansions with key_in switched after the first done.
   - keys_valid drops in the cycle after the first done pulse. The second done occurs exactly 11 cycles after the first.
   - rk10 matches the second key's expected value.
6. CLEAR_ON_RESET=0:
   - Expand the FIPS key, then pulse rst.
   - keys_valid=0, yet reading rk10 still returns d014f9a8c9ee2589e13f0cc8b6630ca6.
